sensor_event_decoder: RTL

//  Consumes the debounced active-low sensor level and turns press activity into discrete events.

---
 rtl/sensor_pkg.sv | 21 ++
 rtl/sensor_evt_buffer.sv | 64 ++++++
 rtl/sensor_event_decoder.sv | 134 +++++++++++++
 3 files changed

// File: rtl/sensor_pkg.sv
// Shared definitions for the sensor path (debouncer, event decoder, game FSM):
// event codes presented to the consumer and the decoder state encodings.
package sensor_pkg;

  typedef enum logic [1:0] {
    EVT_NONE   = 2'b00,
    EVT_TAP    = 2'b01,
    EVT_HOLD   = 2'b10,
    EVT_REPEAT = 2'b11
  } evt_code_e;

  typedef enum logic [1:0] {
    S_WAIT_REL = 2'b00,
    S_IDLE     = 2'b01,
    S_PRESS    = 2'b10,
    S_HELD     = 2'b11
  } state_e;

  localparam logic [7:0] PRESS_COUNT_MAX = 8'hFF;

endpackage

// File: rtl/sensor_evt_buffer.sv
// One-deep event holding register with valid/ack handshake and a sticky
// overrun flag. A new event is accepted when the holder is empty or being
// acknowledged on the same edge; otherwise it is dropped and overrun is set.
module sensor_evt_buffer
  import sensor_pkg::*;
(
  input  logic       clk,
  input  logic       reset,        // synchronous, active-low
  input  logic       raise,
  input  logic [1:0] raise_code,
  input  logic       evt_ack,
  output logic       evt_valid,
  output logic [1:0] evt_code,
  output logic       evt_overrun
);

  logic       valid_q, valid_d;
  logic [1:0] code_q, code_d;
  logic       overrun_q, overrun_d;
  logic       ack_take;

  // Next holder contents from ack and incoming event; a new event wins over ack.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    valid_d   = valid_q;
    code_d    = code_q;
    overrun_d = overrun_q;
    ack_take  = valid_q & evt_ack;

    if (ack_take) begin
      valid_d   = 1'b0;
      code_d    = EVT_NONE;
      overrun_d = 1'b0;
    end

    if (raise) begin
      if (!valid_q || evt_ack) begin
        valid_d = 1'b1;
        code_d  = raise_code;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  // Holder registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!reset) begin
      valid_q   <= 1'b0;
      code_q    <= EVT_NONE;
      overrun_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      code_q    <= code_d;
      overrun_q <= overrun_d;
    end
  end

  assign evt_valid   = valid_q;
  assign evt_code    = code_q;
  assign evt_overrun = overrun_q;

endmodule

// File: rtl/sensor_event_decoder.sv
// Turns the debounced active-low sensor level into TAP / HOLD / REPEAT events
// and presents them through a valid/ack holding register.
// Optional feature: define SENSOR_REPEAT_EN to emit REPEAT events while held.
// Same clock domain as the debouncer, so level_in is used without a synchroniser.
module sensor_event_decoder
  import sensor_pkg::*;
#(
  parameter int unsigned SHORT_MIN    = 3,
  parameter int unsigned LONG_COUNT   = 10,
  parameter int unsigned REPEAT_COUNT = 4
) (
  input  logic       clk,
  input  logic       reset,        // synchronous, active-low
  input  logic       level_in,     // 0 = pressed
  output logic       evt_valid,
  output logic [1:0] evt_code,
  input  logic       evt_ack,
  output logic       evt_overrun,
  output logic       hold_active,
  output logic [7:0] press_count
);

  // Counter must reach LONG_COUNT in PRESS and REPEAT_COUNT in HELD.
  localparam int unsigned CNT_TOP = (REPEAT_COUNT > LONG_COUNT) ? REPEAT_COUNT : LONG_COUNT;
  localparam int unsigned CW      = $clog2(CNT_TOP + 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      press_q, press_d;
  logic [31:0]     cnt_inc;
  logic            raise;
  evt_code_e       raise_code;

  // Press classifier: next state, low-sample count and event raise.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    raise      = 1'b0;
    raise_code = EVT_NONE;
    cnt_inc    = 32'(cnt_q) + 32'd1;

    unique case (state_q)
      S_WAIT_REL: begin
        // A press still down when reset ends must be released before it counts.
        cnt_d = '0;
        if (level_in) state_d = S_IDLE;
      end
      S_IDLE: begin
        cnt_d = '0;
        if (!level_in) begin
          state_d = S_PRESS;
          cnt_d   = CW'(1);
        end
      end
      S_PRESS: begin
        if (!level_in) begin
          if (cnt_inc == LONG_COUNT) begin
            state_d    = S_HELD;
            cnt_d      = '0;
            raise      = 1'b1;
            raise_code = EVT_HOLD;
          end else begin
            cnt_d = CW'(cnt_inc);
          end
        end else begin
          state_d = S_IDLE;
          cnt_d   = '0;
          if (32'(cnt_q) >= SHORT_MIN) begin
            raise      = 1'b1;
            raise_code = EVT_TAP;
          end
        end
      end
      S_HELD: begin
        if (level_in) begin
          // Releasing a long press is silent.
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
`ifdef SENSOR_REPEAT_EN
          if (cnt_inc == REPEAT_COUNT) begin
            cnt_d      = '0;
            raise      = 1'b1;
            raise_code = EVT_REPEAT;
          end else begin
            cnt_d = CW'(cnt_inc);
          end
`else
          cnt_d = cnt_q;
`endif
        end
      end
      default: begin
        state_d = S_WAIT_REL;
        cnt_d   = '0;
      end
    endcase
  end

  // Saturating count of TAP and HOLD events, dropped ones included.
  always_comb begin
    press_d = press_q;
    if (raise && (raise_code != EVT_REPEAT) && (press_q != PRESS_COUNT_MAX))
      press_d = press_q + 8'd1;
  end

  // FSM, counter and press count registers; reset re-arms via WAIT_REL.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_WAIT_REL;
      cnt_q   <= '0;
      press_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  sensor_evt_buffer u_buf (
    .clk         (clk),
    .reset       (reset),
    .raise       (raise),
    .raise_code  (raise_code),
    .evt_ack     (evt_ack),
    .evt_valid   (evt_valid),
    .evt_code    (evt_code),
    .evt_overrun (evt_overrun)
  );

  assign hold_active = (state_q == S_HELD);
  assign press_count = press_q;

endmodule
